// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED PIO sequencer.
// Register map offsets, the step mode encoding and the sequencer FSM states.
package led_seq_pkg;

    typedef enum logic [1:0] {
        STATIC = 2'd0,
        ROTATE = 2'd1,
        BOUNCE = 2'd2,
        COUNT  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PERIOD  = 2'd1;
    localparam logic [1:0] REG_PATTERN = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam logic [1:0] PIO_DATA_OFFSET = 2'd0;

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-period prescaler: counts clk cycles while run is high and emits a
// one-cycle tick on the last count of each period (period 0 behaves as 1).
module led_seq_prescaler #(
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    run,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    tick
);

    logic [PERIOD_WIDTH-1:0] count;
    logic [PERIOD_WIDTH-1:0] limit;

    always_comb begin
        limit = '0;
        if (period != '0) begin
            limit = period - PERIOD_WIDTH'(1);
        end
    end

    assign tick = run && !clear && (count == limit);

    // Held at zero whenever not running so every count phase starts fresh.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || !run || tick) begin
            count <= '0;
        end else begin
            count <= count + PERIOD_WIDTH'(1);
        end
    end

endmodule

// File: rtl/led_pio_sequencer.sv
// Autonomous LED pattern sequencer: steps a seed pattern on a programmable
// tick and pushes every new value to the LED PIO with a one-cycle write.
module led_pio_sequencer
    import led_seq_pkg::*;
#(
    parameter int LED_WIDTH    = 4,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  ctl_address,
    input  logic        ctl_chipselect,
    input  logic        ctl_write_n,
    input  logic [31:0] ctl_writedata,
    output logic [31:0] ctl_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata
);

    // state | meaning
    // IDLE  | disabled, prescaler held at 0, LEDs keep their last value
    // RUN   | counting the step period (waits forever in STATIC mode)
    // WRITE | one-cycle PIO write strobe carrying the current pattern

    state_t                  state;
    logic                    en;
    mode_t                   mode;
    logic [PERIOD_WIDTH-1:0] period;
    logic [LED_WIDTH-1:0]    pattern;
    logic [LED_WIDTH-1:0]    cur_pat;
    logic                    dir;
    logic [15:0]             step_cnt;

    logic                    ctl_wr;
    logic                    wr_ctrl;
    logic                    wr_period;
    logic                    wr_pattern;
    logic                    new_en;
    mode_t                   new_mode;
    logic                    presc_clear;
    logic                    presc_run;
    logic                    tick;
    logic [LED_WIDTH-1:0]    adv_pat;
    logic                    adv_dir;
    logic                    eff_dir;
    logic [31:0]             status;
    logic                    unused_wdata;

    assign ctl_wr     = ctl_chipselect && !ctl_write_n;
    assign wr_ctrl    = ctl_wr && (ctl_address == REG_CTRL);
    assign wr_period  = ctl_wr && (ctl_address == REG_PERIOD);
    assign wr_pattern = ctl_wr && (ctl_address == REG_PATTERN);
    assign new_en     = ctl_writedata[0];
    assign new_mode   = mode_t'(ctl_writedata[2:1]);

    assign unused_wdata = ^ctl_writedata[31:PERIOD_WIDTH];

    assign presc_clear = (wr_period && en) || (wr_pattern && en) ||
                         (wr_ctrl && (!new_en || (en && new_mode != mode)));
    assign presc_run   = (state == RUN) && (mode != STATIC);

    led_seq_prescaler #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (presc_clear),
        .run     (presc_run),
        .period  (period),
        .tick    (tick)
    );

    // Bounce turns around before shifting when already sitting on an end bit,
    // so a multi-bit pattern never shifts a lit bit off the edge.
    always_comb begin
        adv_pat = cur_pat;
        adv_dir = dir;
        eff_dir = dir;
        case (mode)
            ROTATE: adv_pat = {cur_pat[LED_WIDTH-2:0], cur_pat[LED_WIDTH-1]};
            BOUNCE: begin
                if (cur_pat != '0) begin
                    if (!dir && cur_pat[LED_WIDTH-1]) begin
                        eff_dir = 1'b1;
                    end else if (dir && cur_pat[0]) begin
                        eff_dir = 1'b0;
                    end
                    if (eff_dir) begin
                        adv_pat = cur_pat >> 1;
                        adv_dir = !adv_pat[0];
                    end else begin
                        adv_pat = cur_pat << 1;
                        adv_dir = adv_pat[LED_WIDTH-1];
                    end
                end
            end
            COUNT:   adv_pat = cur_pat + LED_WIDTH'(1);
            default: adv_pat = cur_pat;
        endcase
    end

    always_comb begin
        status                  = '0;
        status[LED_WIDTH-1:0]   = cur_pat;
        status[8]               = dir;
        status[31:16]           = step_cnt;
    end

    always_comb begin
        ctl_readdata = '0;
        case (ctl_address)
            REG_CTRL:    ctl_readdata[2:0] = {mode, en};
            REG_PERIOD:  ctl_readdata[PERIOD_WIDTH-1:0] = period;
            REG_PATTERN: ctl_readdata[LED_WIDTH-1:0] = pattern;
            REG_STATUS:  ctl_readdata = status;
            default:     ctl_readdata = '0;
        endcase
    end

    assign pio_address = PIO_DATA_OFFSET;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            en             <= 1'b0;
            mode           <= STATIC;
            period         <= '0;
            pattern        <= '0;
            cur_pat        <= '0;
            dir            <= 1'b0;
            step_cnt       <= '0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
        end else begin
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;

            if (wr_period) begin
                period <= ctl_writedata[PERIOD_WIDTH-1:0];
            end
            if (wr_pattern) begin
                pattern <= ctl_writedata[LED_WIDTH-1:0];
            end
            if (wr_ctrl) begin
                en   <= new_en;
                mode <= new_mode;
            end

            // Any control write takes priority over a tick in the same cycle.
            if (wr_ctrl && !new_en) begin
                state <= IDLE;
            end else if (wr_ctrl && new_en && !en) begin
                cur_pat        <= pattern;
                dir            <= 1'b0;
                step_cnt       <= '0;
                state          <= WRITE;
                pio_chipselect <= 1'b1;
                pio_write_n    <= 1'b0;
                pio_writedata  <= 32'(pattern);
            end else if (wr_pattern && en) begin
                cur_pat        <= ctl_writedata[LED_WIDTH-1:0];
                dir            <= 1'b0;
                step_cnt       <= '0;
                state          <= WRITE;
                pio_chipselect <= 1'b1;
                pio_write_n    <= 1'b0;
                pio_writedata  <= 32'(ctl_writedata[LED_WIDTH-1:0]);
            end else begin
                case (state)
                    IDLE:  state <= IDLE;
                    WRITE: state <= RUN;
                    RUN: begin
                        if (tick && !ctl_wr) begin
                            cur_pat        <= adv_pat;
                            dir            <= adv_dir;
                            step_cnt       <= step_cnt + 16'd1;
                            state          <= WRITE;
                            pio_chipselect <= 1'b1;
                            pio_write_n    <= 1'b0;
                            pio_writedata  <= 32'(adv_pat);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Self-checking bench for led_pio_sequencer: directed and randomized pattern
// runs compared against an arithmetic model of the stepping rules.
module tb_led_pio_sequencer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  ctl_address;
    logic        ctl_chipselect;
    logic        ctl_write_n;
    logic [31:0] ctl_writedata;
    logic [31:0] ctl_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;

    int tests = 0;
    int fails = 0;

    led_pio_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ctl_address    (ctl_address),
        .ctl_chipselect (ctl_chipselect),
        .ctl_write_n    (ctl_write_n),
        .ctl_writedata  (ctl_writedata),
        .ctl_readdata   (ctl_readdata),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the write is taken at the next rising edge.
    task automatic ctl_write(input logic [1:0] addr, input logic [31:0] data);
        ctl_address    = addr;
        ctl_writedata  = data;
        ctl_chipselect = 1'b1;
        ctl_write_n    = 1'b0;
        @(negedge clk);
        ctl_chipselect = 1'b0;
        ctl_write_n    = 1'b1;
    endtask

    task automatic read_reg(input logic [1:0] addr, output logic [31:0] data);
        ctl_address = addr;
        #1;
        data = ctl_readdata;
    endtask

    task automatic wait_strobe(input int budget, output logic seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (pio_chipselect && !pio_write_n) seen = 1'b1;
        end
    endtask

    // Behavioural stepping rules, written in plain arithmetic.
    task automatic model_step(input int mode, inout int pat, inout int dir);
        int right;
        case (mode)
            1: pat = (pat * 2) % 16 + pat / 8;
            2: begin
                if (pat != 0) begin
                    right = dir;
                    if (dir == 0 && pat >= 8) right = 1;
                    if (dir == 1 && pat % 2 == 1) right = 0;
                    if (right == 1) begin
                        pat = pat / 2;
                        dir = (pat % 2 == 1) ? 0 : 1;
                    end else begin
                        pat = (pat * 2) % 16;
                        dir = (pat >= 8) ? 1 : 0;
                    end
                end
            end
            3: pat = (pat + 1) % 16;
            default: pat = pat;
        endcase
    endtask

    function automatic logic [31:0] status_word(input int step, input int dir, input int pat);
        return (step << 16) | (dir << 8) | pat;
    endfunction

    task automatic run_seq(input int mode, input int seed, input int period, input int n, input string tag);
        int pat, dir, gap, cyc;
        logic seen;
        logic [31:0] rd;
        ctl_write(2'd1, 32'(period));
        ctl_write(2'd2, 32'(seed));
        ctl_write(2'd0, 32'((mode << 1) | 1));
        check({tag, " first strobe"}, {30'd0, pio_chipselect, pio_write_n}, 32'd2);
        check({tag, " first value"}, pio_writedata, 32'(seed));
        pat = seed;
        dir = 0;
        gap = ((period == 0) ? 1 : period) + 1;
        for (int k = 1; k <= n; k++) begin
            model_step(mode, pat, dir);
            wait_strobe(gap + 3, seen, cyc);
            check({tag, " interval"}, 32'(cyc), 32'(gap));
            check({tag, " value"}, pio_writedata, 32'(pat));
            read_reg(2'd3, rd);
            check({tag, " status"}, rd, status_word(k, dir, pat));
        end
        // Disable while the last strobe is still in flight.
        ctl_write(2'd0, 32'(mode << 1));
        check({tag, " strobe ends"}, {30'd0, pio_chipselect, pio_write_n}, 32'd1);
        wait_strobe(20, seen, cyc);
        check({tag, " no strobe after disable"}, {31'd0, seen}, 32'd0);
        check({tag, " leds hold"}, pio_writedata, 32'(pat));
    endtask

    initial begin
        logic        seen;
        int          cyc;
        logic [31:0] rd;

        reset_n        = 1'b0;
        ctl_address    = 2'd0;
        ctl_chipselect = 1'b0;
        ctl_write_n    = 1'b1;
        ctl_writedata  = 32'd0;
        repeat (3) @(negedge clk);
        check("reset chipselect", {31'd0, pio_chipselect}, 32'd0);
        check("reset write_n", {31'd0, pio_write_n}, 32'd1);
        check("reset writedata", pio_writedata, 32'd0);
        check("reset address", {30'd0, pio_address}, 32'd0);
        check("reset readdata", ctl_readdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        wait_strobe(10, seen, cyc);
        check("idle no strobe", {31'd0, seen}, 32'd0);

        run_seq(1, 4'b0001, 3, 4, "rotate");
        run_seq(2, 4'b0001, 1, 7, "bounce");
        run_seq(3, 4'hE, 0, 3, "count");

        // Static mode: one write on enable, then nothing.
        ctl_write(2'd2, 32'h9);
        ctl_write(2'd0, 32'h1);
        check("static first value", pio_writedata, 32'h9);
        wait_strobe(20, seen, cyc);
        check("static no step", {31'd0, seen}, 32'd0);
        ctl_write(2'd0, 32'h0);

        // PATTERN write landing on the same edge as a due tick.
        ctl_write(2'd1, 32'd4);
        ctl_write(2'd2, 32'h1);
        ctl_write(2'd0, 32'h3);
        wait_strobe(8, seen, cyc);
        check("midcount pre interval", 32'(cyc), 32'd5);
        check("midcount pre value", pio_writedata, 32'h2);
        repeat (4) @(negedge clk);
        ctl_write(2'd2, 32'h5);
        check("midcount reload strobe", {30'd0, pio_chipselect, pio_write_n}, 32'd2);
        check("midcount reload value", pio_writedata, 32'h5);
        read_reg(2'd3, rd);
        check("midcount status", rd, 32'h5);
        wait_strobe(8, seen, cyc);
        check("midcount restart interval", 32'(cyc), 32'd5);
        check("midcount restart value", pio_writedata, 32'hA);
        ctl_write(2'd0, 32'h2);

        for (int i = 0; i < 5; i++) begin
            run_seq(int'($urandom_range(1, 3)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 5)), 5, "random");
        end

        // Reset in the middle of a write strobe.
        ctl_write(2'd1, 32'd2);
        ctl_write(2'd2, 32'h3);
        ctl_write(2'd0, 32'h3);
        wait_strobe(6, seen, cyc);
        check("prereset strobe", {31'd0, seen}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async reset write_n", {31'd0, pio_write_n}, 32'd1);
        check("async reset chipselect", {31'd0, pio_chipselect}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), rd);
            check("reset regs zero", rd, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        wait_strobe(10, seen, cyc);
        check("post reset idle", {31'd0, seen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_pio_sequencer.md
# led_pio_sequencer

Autonomous LED pattern controller that drives the 4-bit LED PIO over its Avalon-MM slave port. Software configures the mode, the step period and the seed pattern through a small Avalon-MM control slave. The block then steps the pattern on a programmable tick and issues a single-cycle write to PIO offset 0 on every change. It sits between the system interconnect and the LED PIO, and replaces CPU-driven LED updates.

## Interface
- LED_WIDTH, 4, pattern width; must equal the PIO data width
- PERIOD_WIDTH, 24, width of the step-period register and prescaler
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ctl_address  in  2  control register select
- ctl_chipselect  in  1  control slave select
- ctl_write_n  in  1  active-low write strobe
- ctl_writedata  in  32  control write data
- ctl_readdata  out  32  control read data; combinational, zero wait states
- pio_address  out  2  to PIO address; constant 0
- pio_chipselect  out  1  to PIO chipselect; pulses with each write
- pio_write_n  out  1  to PIO write_n; active-low write strobe
- pio_writedata  out  32  to PIO writedata; {zeros, pattern}

## Operation
- Registers (all zero after reset):
  - 0 CTRL: bit0 EN; bits2:1 MODE (0 static, 1 rotate-left, 2 bounce, 3 binary count).
  - 1 PERIOD: bits PERIOD_WIDTH-1:0, clk cycles per step; 0 is treated as 1.
  - 2 PATTERN: LED_WIDTH bits, seed value.
  - 3 STATUS: read-only; bits LED_WIDTH-1:0 current pattern, bit 8 direction (1 = moving right), bits 31:16 step count.
- Writes to STATUS are ignored. Reads of unused bits return 0.
- FSM states: IDLE, RUN, WRITE.
  - IDLE: prescaler is held at 0.
    - Leave IDLE when EN is written 1.
    - On entry, the current pattern is loaded from PATTERN.
    - The next state is WRITE.
  - RUN: prescaler counts up.
    - At count == max(PERIOD,1)-1, the prescaler wraps to 0.
    - The pattern advances per MODE, the step count increments (16-bit wrap), and the FSM goes to WRITE.
    - In MODE 0 no tick steps occur; RUN waits.
  - WRITE: exactly one cycle with pio_chipselect=1 and pio_write_n=0, carrying pio_writedata = current pattern. The next state is RUN.
- Advance rules:
  - Rotate: MSB wraps to LSB. A zero pattern stays zero.
  - Bounce: shift one position in the current direction. Direction flips after reaching bit LED_WIDTH-1 or bit 0, so no step is lost at the ends. A pattern of 0 stays 0.
  - Count: +1 modulo 2^LED_WIDTH.
- Writing PATTERN while EN=1:
  - Reload the current pattern, clear the prescaler and step count, reset direction to left.
  - Go to WRITE on the next cycle.
- Writing PERIOD while EN=1: clear the prescaler. The new period applies from the next count.
- Writing CTRL with EN=0: go to IDLE. No further PIO writes occur; the LEDs hold their last value. A WRITE already in flight completes.
- Writing CTRL with EN=1 while running and MODE changed: the current pattern is kept and the prescaler is cleared.
- Simultaneous tick and control write in the same cycle: the control write wins, and the tick is discarded.

## Timing
- Reset values: ctl_readdata 0, pio_address 0, pio_chipselect 0, pio_write_n 1, pio_writedata 0; FSM in IDLE.
- Reset asserted mid-operation aborts any WRITE immediately (pio_write_n returns to 1 asynchronously).
- Control writes take effect at the clk edge where ctl_chipselect=1 and ctl_write_n=0.
- Enable to first PIO write: the EN write edge puts the FSM in WRITE; the write strobe is visible during the following cycle.
- Step period in RUN: exactly max(PERIOD,1)+1 cycles between consecutive PIO write strobes, i.e. the count phase plus the WRITE cycle.
- ctl_readdata is combinational from ctl_address and the registers, valid in the same cycle. STATUS reflects the pattern registered at the previous edge.
- pio_* outputs are registered; no combinational path from the ctl_* inputs.

## Structure
- Package led_seq_pkg holds:
  - MODE enum: STATIC, ROTATE, BOUNCE, COUNT.
  - FSM state enum: IDLE, RUN, WRITE.
  - Register offset constants: CTRL=0, PERIOD=1, PATTERN=2, STATUS=3.
  - PIO data offset constant: 0.
- Sub-module led_seq_prescaler:
  - Ports: clk, reset_n, clear, run, period → tick.
  - Tick is one cycle wide.
- Pattern-advance logic stays in the top-level module.

## Test plan
- Reset → all outputs at their reset values. Enable with MODE=1, PATTERN=4'b0001, PERIOD=3 → first write 0001, then 0010, 0100, 1000, 0001, with strobes 4 cycles apart.
- MODE=2, PATTERN=4'b0001, PERIOD=1 → writes 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; STATUS direction bit toggles at the ends.
- MODE=3, PATTERN=4'hE, PERIOD=0 → writes E, F, 0, 1 at a 2-cycle spacing (PERIOD 0 treated as 1). STATUS step count reads 3 after the third step.
- PATTERN=4'h5 written mid-count with a tick due the same cycle → no step. The next strobe carries 5 one cycle later, and the prescaler restarts.
- EN cleared during WRITE → that strobe completes and no further strobes follow. reset_n pulsed low mid-run → pio_write_n=1 and pio_chipselect=0 immediately; all registers read 0.
